// File: rtl/led_fade_ctrl.sv
// Command-driven RGB fade sequencer feeding the PWM stage (3 LEDs, ms time base).
// Optional registered gamma stage on colour outputs: define LED_FADE_GAMMA_EN.
module led_fade_ctrl #(
    parameter int CLK_FRQ_MHZ = 24,
    parameter int TICK_US     = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_led,
    input  logic [7:0] cmd_red,
    input  logic [7:0] cmd_green,
    input  logic [7:0] cmd_blue,
    input  logic [7:0] cmd_dc,
    input  logic [7:0] cmd_step,
    output logic [7:0] led1_red_value,
    output logic [7:0] led1_green_value,
    output logic [7:0] led1_blue_value,
    output logic [7:0] led2_red_value,
    output logic [7:0] led2_green_value,
    output logic [7:0] led2_blue_value,
    output logic [7:0] led3_red_value,
    output logic [7:0] led3_green_value,
    output logic [7:0] led3_blue_value,
    output logic [7:0] led1_DC_value,
    output logic [7:0] led2_DC_value,
    output logic [7:0] led3_DC_value,
    output logic [2:0] fade_busy,
    output logic       cmd_err
);

    localparam int PRE_N = CLK_FRQ_MHZ * TICK_US;
    localparam int PRE_W = (PRE_N > 1) ? $clog2(PRE_N) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FADE = 1'b1;

    logic [PRE_W-1:0] r_pre;
    logic             r_ready;
    logic             r_err;
    logic             w_tick;
    logic             w_acc;

    logic [2:0][2:0][7:0] w_cur;
    logic [2:0][2:0][7:0] w_out;
    logic [2:0][7:0]      w_dc;

    assign w_tick = (r_pre == PRE_MAX);
    assign w_acc  = cmd_valid & r_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre   <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
            r_ready <= ~w_acc;
            r_err   <= w_acc & (cmd_led == 2'd3);
        end
    end

    genvar n;
    generate
        for (n = 0; n < 3; n++) begin : g_led
            logic [2:0][7:0] r_cur;
            logic [2:0][7:0] r_tgt;
            logic [2:0][7:0] w_cmd;
            logic [2:0][7:0] w_nxt;
            logic [7:0]      r_step;
            logic [7:0]      r_cnt;
            logic [7:0]      r_dc;
            logic [0:0]      r_state;
            logic            w_sel;
            logic            w_diff;
            logic            w_done;

            assign w_sel = w_acc & (cmd_led == 2'(n));
            assign w_cmd = {cmd_blue, cmd_green, cmd_red};

            always_comb begin
                w_nxt  = r_cur;
                w_diff = 1'b0;
                w_done = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    if (r_cur[c] < r_tgt[c])
                        w_nxt[c] = r_cur[c] + 8'd1;
                    else if (r_cur[c] > r_tgt[c])
                        w_nxt[c] = r_cur[c] - 8'd1;
                    if (w_cmd[c] != r_cur[c])
                        w_diff = 1'b1;
                    if (w_nxt[c] != r_tgt[c])
                        w_done = 1'b0;
                end
            end

            // A fresh accept always restarts the step phase, even on a tick edge.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cur   <= '0;
                    r_tgt   <= '0;
                    r_step  <= '0;
                    r_cnt   <= '0;
                    r_dc    <= '0;
                    r_state <= S_IDLE;
                end else if (w_sel) begin
                    r_tgt  <= w_cmd;
                    r_step <= cmd_step;
                    r_dc   <= cmd_dc;
                    r_cnt  <= '0;
                    if (cmd_step == 8'd0) begin
                        r_cur   <= w_cmd;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= w_diff ? S_FADE : S_IDLE;
                    end
                end else if (r_state == S_FADE && w_tick) begin
                    if (r_cnt == r_step - 8'd1) begin
                        r_cur <= w_nxt;
                        r_cnt <= '0;
                        if (w_done)
                            r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end

            assign w_cur[n]     = r_cur;
            assign w_dc[n]      = r_dc;
            assign fade_busy[n] = (r_state == S_FADE);
        end
    endgenerate

`ifdef LED_FADE_GAMMA_EN
    function automatic logic [7:0] gamma8(input logic [7:0] v);
        logic [15:0] p;
        p = 16'(v) * 16'(v) + 16'd255;
        return p[15:8];
    endfunction

    logic [2:0][2:0][7:0] r_gam;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gam <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                for (int c = 0; c < 3; c++)
                    r_gam[i][c] <= gamma8(w_cur[i][c]);
        end
    end

    assign w_out = r_gam;
`else
    assign w_out = w_cur;
`endif

    assign cmd_ready        = r_ready;
    assign cmd_err          = r_err;
    assign led1_red_value   = w_out[0][0];
    assign led1_green_value = w_out[0][1];
    assign led1_blue_value  = w_out[0][2];
    assign led2_red_value   = w_out[1][0];
    assign led2_green_value = w_out[1][1];
    assign led2_blue_value  = w_out[1][2];
    assign led3_red_value   = w_out[2][0];
    assign led3_green_value = w_out[2][1];
    assign led3_blue_value  = w_out[2][2];
    assign led1_DC_value    = w_dc[0];
    assign led2_DC_value    = w_dc[1];
    assign led3_DC_value    = w_dc[2];

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Directed scoreboard bench for led_fade_ctrl (4 MHz, 1 us tick => tick every 4 clocks).
// Gamma-specific steps are built only with LED_FADE_GAMMA_EN.
module tb_led_fade_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_led = '0;
    logic [7:0] cmd_red = '0, cmd_green = '0, cmd_blue = '0;
    logic [7:0] cmd_dc = '0, cmd_step = '0;
    logic [7:0] l1r, l1g, l1b, l2r, l2g, l2b, l3r, l3g, l3b;
    logic [7:0] dc1, dc2, dc3;
    logic [2:0] fade_busy;
    logic       cmd_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    led_fade_ctrl #(.CLK_FRQ_MHZ(4), .TICK_US(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_led(cmd_led), .cmd_red(cmd_red),
        .cmd_green(cmd_green), .cmd_blue(cmd_blue),
        .cmd_dc(cmd_dc), .cmd_step(cmd_step),
        .led1_red_value(l1r), .led1_green_value(l1g), .led1_blue_value(l1b),
        .led2_red_value(l2r), .led2_green_value(l2g), .led2_blue_value(l2b),
        .led3_red_value(l3r), .led3_green_value(l3g), .led3_blue_value(l3b),
        .led1_DC_value(dc1), .led2_DC_value(dc2), .led3_DC_value(dc3),
        .fade_busy(fade_busy), .cmd_err(cmd_err)
    );

    function automatic logic [7:0] obs(input int sel);
        logic [7:0] v;
        v = 8'hxx;
        case (sel)
            0: v = l1r;
            1: v = l1g;
            2: v = l1b;
            3: v = l2r;
            4: v = l2g;
            5: v = l2b;
            6: v = l3r;
            7: v = l3g;
            8: v = l3b;
            9: v = dc1;
            10: v = dc2;
            11: v = dc3;
            12: v = {5'b0, fade_busy};
            13: v = {7'b0, cmd_ready};
            14: v = {7'b0, cmd_err};
            default: v = 8'hxx;
        endcase
        return v;
    endfunction

    task automatic push(input string tag, input int sel, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic drain();
        while (sbq.size() > 0) begin
            exp_t e;
            logic [7:0] o;
            e = sbq.pop_front();
            o = obs(e.sel);
            n_vec++;
            assert (o === e.val) else begin
                n_err++;
                $error("FAIL %s[%0d]: observed %0d expected %0d", e.tag, e.sel, o, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input int o, input int e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] led, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] dc, input logic [7:0] st);
        int w;
        w = 0;
        while (!cmd_ready && w < 20) begin
            cyc();
            w++;
        end
        chk("ready_wait", int'(cmd_ready), 1);
        cmd_led   = led;
        cmd_red   = r;
        cmd_green = g;
        cmd_blue  = b;
        cmd_dc    = dc;
        cmd_step  = st;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        for (int s = 0; s < 15; s++)
            push("in_reset", s, 8'd0);
        drain();

        #2 rst = 1'b1;
        push("ready_rel", 13, 8'd0);
        drain();
        cyc();
        push("ready_up", 13, 8'd1);
        push("busy_rel", 12, 8'd0);
        drain();

        send(2'd1, 8'd200, 8'd0, 8'd50, 8'd128, 8'd0);
        push("l2_jump", 10, 8'd128);
        push("l2_jump", 12, 8'd0);
        push("l2_jump", 13, 8'd0);
`ifdef LED_FADE_GAMMA_EN
        drain();
        cyc();
`endif
        push("l2_jump", 3, 8'd200);
        push("l2_jump", 4, 8'd0);
        push("l2_jump", 5, 8'd50);
        drain();
`ifndef LED_FADE_GAMMA_EN
        cyc();
        push("ready_back", 13, 8'd1);
        drain();

        begin
            int c, lastc, last, steps;
            send(2'd0, 8'd10, 8'd0, 8'd0, 8'd7, 8'd3);
            push("l1_fade_start", 12, 8'd1);
            push("l1_fade_start", 9, 8'd7);
            push("l1_fade_start", 0, 8'd0);
            drain();
            c = 0; lastc = 0; last = 0; steps = 0;
            while (int'(l1r) != 10 && c < 2000) begin
                cyc();
                c++;
                if (int'(l1r) != last) begin
                    push("fade_up", 0, 8'(last + 1));
                    push("fade_up_busy", 12, (last + 1 == 10) ? 8'd0 : 8'd1);
                    drain();
                    if (steps == 0)
                        chk("first_step_win", int'(c >= 9 && c <= 12), 1);
                    else
                        chk("step_period", c - lastc, 12);
                    steps++;
                    lastc = c;
                    last = int'(l1r);
                end
            end
            chk("fade_up_end", int'(l1r), 10);
            chk("fade_up_len", int'(c >= 117 && c <= 120), 1);

            send(2'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd0);
            push("l1_zero", 0, 8'd0);
            drain();
            send(2'd0, 8'd10, 8'd0, 8'd0, 8'd7, 8'd3);
            c = 0;
            while (int'(l1r) != 5 && c < 500) begin
                cyc();
                c++;
            end
            chk("wait_red5", int'(l1r), 5);

            send(2'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd1);
            push("retarget_nojump", 0, 8'd5);
            push("retarget_busy", 12, 8'd1);
            drain();
            c = 0; lastc = 0; last = 5; steps = 0;
            while (int'(l1r) != 0 && c < 200) begin
                cyc();
                c++;
                if (int'(l1r) != last) begin
                    push("fade_down", 0, 8'(last - 1));
                    push("fade_down_busy", 12, (last - 1 == 0) ? 8'd0 : 8'd1);
                    drain();
                    if (steps == 0)
                        chk("down_first_win", int'(c >= 1 && c <= 4), 1);
                    else
                        chk("down_period", c - lastc, 4);
                    steps++;
                    lastc = c;
                    last = int'(l1r);
                end
            end
            chk("fade_down_end", int'(l1r), 0);
            chk("fade_down_steps", steps, 5);
        end
`endif

        send(2'd3, 8'd99, 8'd99, 8'd99, 8'd99, 8'd0);
        push("err_pulse", 14, 8'd1);
        push("err_keep", 3, 8'd200);
        push("err_keep", 10, 8'd128);
        push("err_keep", 0, 8'd0);
        push("err_keep", 11, 8'd0);
        push("err_busy", 12, 8'd0);
        drain();
        cyc();
        push("err_clear", 14, 8'd0);
        push("err_keep2", 3, 8'd200);
        drain();

        send(2'd2, 8'd255, 8'd0, 8'd0, 8'd40, 8'd2);
        push("l3_start", 12, 8'd4);
        push("l3_start", 11, 8'd40);
        drain();
        repeat (20) cyc();
        chk("l3_moving", int'(l3r != 8'd0), 1);
        #2 rst = 1'b0;
        #1;
        for (int s = 0; s < 15; s++)
            push("async_rst", s, 8'd0);
        drain();
        rst = 1'b1;
        repeat (40) cyc();
        push("no_resume", 12, 8'd0);
        push("no_resume", 6, 8'd0);
        push("no_resume", 11, 8'd0);
        drain();

`ifdef LED_FADE_GAMMA_EN
        send(2'd0, 8'd128, 8'd0, 8'd0, 8'd9, 8'd0);
        push("gam_dc", 9, 8'd9);
        push("gam_lat", 0, 8'd0);
        drain();
        cyc();
        push("gam_128", 0, 8'd64);
        drain();
        send(2'd0, 8'd255, 8'd0, 8'd0, 8'd9, 8'd0);
        cyc();
        push("gam_255", 0, 8'd255);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_fade_ctrl.md
# led_fade_ctrl

Command-driven colour sequencer that sits directly upstream of the RGB PWM stage. It holds per-LED target colour, brightness and fade rate for three RGB LEDs. It ramps each 8-bit colour code linearly toward its target on a millisecond time base. It drives the `ledN_{red,green,blue,DC}_value` inputs of the PWM stage, so the MCU-facing register logic issues one command instead of many per-step writes.

## Interface
- `CLK_FRQ_MHZ`, 24, clock frequency in MHz.
- `TICK_US`, 1000, fade time base in µs; one tick every `CLK_FRQ_MHZ*TICK_US` clocks.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset: asynchronous, active-low (0 = reset).
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_led`  in  2  target LED: 0=LED1, 1=LED2, 2=LED3, 3=invalid.
- `cmd_red`, `cmd_green`, `cmd_blue`  in  8 each  target colour codes.
- `cmd_dc`  in  8  brightness duty-cycle code.
- `cmd_step`  in  8  ticks per colour unit; 0 = jump immediately.
- `led1_red_value` … `led3_blue_value`  out  8 each  nine current colour codes to the PWM stage.
- `led1_DC_value`, `led2_DC_value`, `led3_DC_value`  out  8 each  brightness codes.
- `fade_busy`  out  3  bit N-1 is high while LED N is ramping.
- `cmd_err`  out  1  one-cycle pulse when an invalid command is dropped.

## Operation
- Prescaler: counts 0..`CLK_FRQ_MHZ*TICK_US`-1 and wraps. A one-cycle `tick` fires on the wrap. The prescaler free-runs and is shared by all LEDs.
- Handshake: a command is accepted on a rising `clk` edge with `cmd_valid & cmd_ready`.
  - `cmd_ready` drops for exactly the one cycle following an accept, then returns high.
  - `cmd_ready` is 0 while in reset.
  - `cmd_valid` without `cmd_ready` is ignored. The sender holds the command until it is accepted.
- Accept with `cmd_led`=3: no state change; `cmd_err`=1 for the next cycle.
- Accept with a valid LED:
  - Target RGB, step and DC registers update.
  - `ledN_DC_value` takes `cmd_dc` at once; brightness never fades.
  - That LED's step counter clears.
- Per-LED FSM, IDLE/FADE:
  - IDLE→FADE on accept with `cmd_step`≠0 and any current≠target.
  - Accept with `cmd_step`=0: all three current values load their targets on the accept edge; the LED stays in or enters IDLE.
  - In FADE, on each tick the step counter increments. When it equals `step-1`, every colour with current≠target moves ±1 toward its target and the counter clears.
  - FADE→IDLE on the same edge the last colour reaches its target.
  - `fade_busy[N-1]` = (state==FADE).
  - Accept for an LED already in FADE retargets from the present current values. There is no jump and the counter clears.
- Arithmetic: colours are 8-bit unsigned and saturate at 0/255 by construction (the step is always toward the target). The step counter is 8-bit; `step-1` comparison is 8-bit.
- Commands for different LEDs never interact. Fades on other LEDs continue through any accept.

## Timing
- Reset values: all 12 value outputs 0, `fade_busy`=0, `cmd_err`=0, `cmd_ready`=0, prescaler/step counters 0, FSMs IDLE. `cmd_ready` goes high on the first edge after reset release.
- Accept edge E: DC output (and colours, for step=0) are visible after E, i.e. 1-cycle latency. `fade_busy` is set after E.
- First colour change of a fade comes `step` ticks after E (phase jitter ≤1 tick). A full 0→255 fade takes 255·step ticks.
- Tick and accept on the same edge: the accept wins for that LED (counter clears, no step that edge). Other LEDs step normally.
- Reset asserted mid-fade: all outputs return to reset values asynchronously. No fade resumes after release.

## Configuration
- `LED_FADE_GAMMA_EN` defined:
  - The nine colour outputs pass through a registered gamma stage, out = (v·v+255)>>8 (16-bit product): 0→0, 128→64, 255→255.
  - Colour latency becomes 2 cycles.
  - DC outputs and `fade_busy` are not delayed.
- Undefined: colour outputs are the linear current values, with 1-cycle latency.

## Test plan
All scenarios use `CLK_FRQ_MHZ`=4 and `TICK_US`=1, so a tick fires every 4 clocks.

- Reset release, no commands → all values 0, `cmd_ready`=1 one cycle after release, `fade_busy`=0.
- LED2 cmd R=200,G=0,B=50,DC=128, step=0 → next cycle `led2_*`=200/0/50, DC=128, `fade_busy`=000, `cmd_ready` low exactly one cycle.
- LED1 cmd R=10, step=3 from 0 → `led1_red_value` +1 every 3 ticks (12 clocks); reaches 10 after 30 ticks; `fade_busy[0]` falls on that edge.
- Mid-fade (red=5, rising) LED1 cmd R=0, step=1 → red counts 5→0, one per tick, with no jump.
- `cmd_led`=3 → `cmd_err` one-cycle pulse, outputs unchanged; then `rst`=0 mid-fade on LED3 → all outputs 0 immediately.
- With `LED_FADE_GAMMA_EN`: step=0 cmd R=128 → `led1_red_value`=64 two cycles after accept; R=255 gives 255.
